barrel_unrotate: RTL

- Multi-cycle left-rotator; the inverse of the team's right-rotating barrel shifter.
- Takes a word rotated right by sel and rotates it left by the same sel, one bit position per clock.
- The original word is restored: barrel_unrotate(ror(d,s), s) == d.
- Sits on the receive side of the barrel datapath; Load/done handshake with busy back-pressure.

---
 rtl/barrel_unrotate.sv | 84 ++++++++
 1 files changed

// File: rtl/barrel_unrotate.sv
// rtl/barrel_unrotate.sv - multi-cycle left rotator that undoes the barrel shifter's right rotation
module barrel_unrotate #(
    parameter int WIDTH = 8,
    parameter int SELW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Load,
    input  logic [SELW-1:0]  sel,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_reg;
    logic [SELW-1:0]  count;
    logic [WIDTH-1:0] rot_next;

    // One-position left rotate of the working register; the MSB wraps into the LSB
    always_comb begin
        rot_next = {sh_reg[WIDTH-2:0], sh_reg[WIDTH-1]};
    end

    // Control FSM: capture on Load in IDLE, rotate once per edge, then a one-cycle DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sh_reg   <= '0;
            count    <= '0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Load) begin
                        sh_reg <= data_in;
                        count  <= sel;
                        busy   <= 1'b1;
                        if (sel == '0) begin
                            // Zero rotate: the captured word is already the answer
                            data_out <= data_in;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            done  <= 1'b0;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    sh_reg <= rot_next;
                    count  <= count - SELW'(1);
                    if (count == SELW'(1)) begin
                        // Last step: publish the post-shift value directly
                        data_out <= rot_next;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // No back-to-back acceptance; Load here is dropped
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
